elev_ctrl_n: RTL and testbench

Parametrised elevator car controller for an N-floor shaft. It takes the registered effective-request vector and drives the door, the car motion, the one-hot car position and the travel direction. Direction is chosen internally with a SCAN (collective) policy. Door-open and floor-to-floor travel times come from internal counters, so no external endRun/endOpen timers are needed. It sits between the request register (fed back through `serviced`) and the display/door/motor drivers.

---
 rtl/elev_ctrl_n_pkg.sv | 33 +++
 rtl/elev_ctrl_n_if.sv | 25 ++
 rtl/elev_ctrl_n_tick_timer.sv | 25 ++
 rtl/elev_ctrl_n.sv | 177 +++++++++++++++++
 tb/tb_elev_ctrl_n.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elev_ctrl_n_pkg.sv
// Shared types and helpers for the elevator car controller.
// Position-relative request masks are computed at a fixed maximum width.
package elev_pkg;

    localparam int unsigned MAX_FLOORS = 32;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_IDLE = 2'b01,
        ST_MOVE = 2'b10,
        ST_DOOR = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    typedef struct packed {
        logic [MAX_FLOORS-1:0] above;
        logic [MAX_FLOORS-1:0] below;
    } floor_masks_t;

    // Floors strictly above / strictly below a one-hot car position.
    function automatic floor_masks_t floor_masks(input logic [MAX_FLOORS-1:0] pos);
        floor_masks_t m;
        m.below = pos - MAX_FLOORS'(1);
        m.above = ~(pos | m.below);
        return m;
    endfunction

endpackage

// File: rtl/elev_ctrl_n_if.sv
// Request/command bundle between the request register, drivers and the car controller.
interface elev_ctrl_n_if #(
    parameter int unsigned FLOORS = 4
);
    logic              switch;
    logic [FLOORS-1:0] eff_req;
    logic              door_hold;
    logic [1:0]        state;
    logic [FLOORS-1:0] position;
    logic [1:0]        dir;
    logic              opendoor;
    logic              mv2nxt;
    logic [FLOORS-1:0] serviced;
    logic              arrive;

    modport master (
        output switch, eff_req, door_hold,
        input  state, position, dir, opendoor, mv2nxt, serviced, arrive
    );

    modport slave (
        input  switch, eff_req, door_hold,
        output state, position, dir, opendoor, mv2nxt, serviced, arrive
    );
endinterface

// File: rtl/elev_ctrl_n_tick_timer.sv
// Loadable down-counter shared by travel and door timing; done while value is 1.
module elev_tick_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_done_c
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done_c = (r_count == W'(1));
endmodule

// File: rtl/elev_ctrl_n.sv
// SCAN elevator car controller: door, motion, position and direction for an N-floor shaft.
// Door and travel durations come from one shared internal tick timer.
module elev_ctrl_n
    import elev_pkg::*;
#(
    parameter int unsigned FLOORS     = 4,
    parameter int unsigned MOVE_TICKS = 64,
    parameter int unsigned DOOR_TICKS = 96,
    parameter int unsigned HOME       = 0
) (
    input logic         clk,
    input logic         rst,
    elev_ctrl_n_if.slave bus
);
    localparam int unsigned TICK_MAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int unsigned TW       = $clog2(TICK_MAX + 1);
    localparam logic [FLOORS-1:0] HOME_POS = FLOORS'(1) << HOME;

    state_e            r_state, w_state_nxt;
    dir_e              r_dir, w_dir_nxt, w_want_dir;
    logic [FLOORS-1:0] r_position, w_position_nxt;
    logic [FLOORS-1:0] r_serviced, w_serviced_nxt;
    logic              r_opendoor, w_opendoor_nxt;
    logic              r_mv2nxt, w_mv2nxt_nxt;
    logic              r_arrive, w_arrive_nxt;

    floor_masks_t      w_masks;
    logic              w_here, w_any_above, w_any_below, w_door_reload;
    logic              w_tmr_load, w_tmr_en, w_tmr_done_c;
    logic [TW-1:0]     w_tmr_val;

    assign w_masks     = floor_masks(MAX_FLOORS'(r_position));
    assign w_here      = |(bus.eff_req & r_position);
    assign w_any_above = |(MAX_FLOORS'(bus.eff_req) & w_masks.above);
    assign w_any_below = |(MAX_FLOORS'(bus.eff_req) & w_masks.below);
    // While our own clear strobe is in flight the car-floor bit is stale, not new.
    assign w_door_reload = w_here && (r_serviced == '0);

    // SCAN choice: keep heading while work remains that way, else turn, else prefer up.
    always_comb begin
        w_want_dir = DIR_NONE;
        case (r_dir)
            DIR_UP: begin
                if (w_any_above)      w_want_dir = DIR_UP;
                else if (w_any_below) w_want_dir = DIR_DOWN;
            end
            DIR_DOWN: begin
                if (w_any_below)      w_want_dir = DIR_DOWN;
                else if (w_any_above) w_want_dir = DIR_UP;
            end
            default: begin
                if (w_any_above)      w_want_dir = DIR_UP;
                else if (w_any_below) w_want_dir = DIR_DOWN;
            end
        endcase
    end

    elev_tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .i_val    (w_tmr_val),
        .o_done_c (w_tmr_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_position <= HOME_POS;
            r_dir      <= DIR_NONE;
            r_opendoor <= 1'b0;
            r_mv2nxt   <= 1'b0;
            r_serviced <= '0;
            r_arrive   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_position <= w_position_nxt;
            r_dir      <= w_dir_nxt;
            r_opendoor <= w_opendoor_nxt;
            r_mv2nxt   <= w_mv2nxt_nxt;
            r_serviced <= w_serviced_nxt;
            r_arrive   <= w_arrive_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!bus.switch) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:  w_state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (w_here)                       w_state_nxt = ST_DOOR;
                    else if (w_want_dir != DIR_NONE)  w_state_nxt = ST_MOVE;
                end
                ST_MOVE: if (w_tmr_done_c) w_state_nxt = ST_IDLE;
                ST_DOOR: begin
                    if (!w_door_reload && !bus.door_hold && w_tmr_done_c) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        w_position_nxt = r_position;
        w_dir_nxt      = r_dir;
        w_opendoor_nxt = r_opendoor;
        w_mv2nxt_nxt   = r_mv2nxt;
        w_serviced_nxt = '0;
        w_arrive_nxt   = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_en       = 1'b0;
        w_tmr_val      = '0;
        if (!bus.switch) begin
            // Disabling parks the car at home at once, even mid-travel.
            w_position_nxt = HOME_POS;
            w_dir_nxt      = DIR_NONE;
            w_opendoor_nxt = 1'b0;
            w_mv2nxt_nxt   = 1'b0;
            w_tmr_load     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_here) begin
                        w_opendoor_nxt = 1'b1;
                        w_serviced_nxt = r_position;
                        w_tmr_load     = 1'b1;
                        w_tmr_val      = TW'(DOOR_TICKS);
                    end else begin
                        w_dir_nxt = w_want_dir;
                        if (w_want_dir != DIR_NONE) begin
                            w_mv2nxt_nxt = 1'b1;
                            w_tmr_load   = 1'b1;
                            w_tmr_val    = TW'(MOVE_TICKS);
                        end
                    end
                end
                ST_MOVE: begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_done_c) begin
                        w_position_nxt = (r_dir == DIR_UP) ? (r_position << 1) : (r_position >> 1);
                        w_arrive_nxt   = 1'b1;
                        w_mv2nxt_nxt   = 1'b0;
                    end
                end
                ST_DOOR: begin
                    if (w_door_reload) begin
                        w_serviced_nxt = r_position;
                        w_tmr_load     = 1'b1;
                        w_tmr_val      = TW'(DOOR_TICKS);
                    end else if (!bus.door_hold) begin
                        w_tmr_en = 1'b1;
                        if (w_tmr_done_c) w_opendoor_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state    = r_state;
    assign bus.position = r_position;
    assign bus.dir      = r_dir;
    assign bus.opendoor = r_opendoor;
    assign bus.mv2nxt   = r_mv2nxt;
    assign bus.serviced = r_serviced;
    assign bus.arrive   = r_arrive;

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(r_position));
    a_excl:   assert property (@(posedge clk) disable iff (rst) !(r_opendoor && r_mv2nxt));
    a_bounds: assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_MOVE && w_tmr_done_c) |->
        ((r_dir == DIR_UP && !r_position[FLOORS-1]) || (r_dir == DIR_DOWN && !r_position[0])));
endmodule

// File: tb/tb_elev_ctrl_n.sv
// Self-checking bench for elev_ctrl_n: directed scenarios plus random traffic vs a floor-level model.
module tb_elev_ctrl_n;
    localparam int FL = 4;
    localparam int MT = 4;
    localparam int DT = 3;
    localparam int HM = 0;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    int          errors = 0;
    int          checks = 0;

    // Reference model: mode 0 off, 1 idle, 2 travelling, 3 door; dir 0 none, 1 up, 2 down
    int m_mode = 0, m_floor = HM, m_dir = 0, m_cnt = 0;
    int m_od = 0, m_mv = 0, m_srv = 0, m_arr = 0;

    elev_ctrl_n_if #(.FLOORS(FL)) bus ();

    elev_ctrl_n #(.FLOORS(FL), .MOVE_TICKS(MT), .DOOR_TICKS(DT), .HOME(HM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input logic [3:0] v);
        req = v;
        bus.eff_req = v;
    endtask

    task automatic model_step();
        bit here, above, below;
        int prev_srv, want;
        if (rst || !bus.switch) begin
            m_mode = 0; m_floor = HM; m_dir = 0; m_cnt = 0;
            m_od = 0; m_mv = 0; m_srv = 0; m_arr = 0;
            return;
        end
        here = req[m_floor];
        above = 0; below = 0;
        for (int i = 0; i < FL; i++) begin
            if (req[i] && i > m_floor) above = 1;
            if (req[i] && i < m_floor) below = 1;
        end
        prev_srv = m_srv;
        m_srv = 0;
        m_arr = 0;
        case (m_mode)
            0: m_mode = 1;
            1: begin
                if (here) begin
                    m_mode = 3; m_od = 1; m_srv = 1 << m_floor; m_cnt = DT;
                end else begin
                    if ((m_dir == 1 && above) || (m_dir == 2 && below)) want = m_dir;
                    else if (above) want = 1;
                    else if (below) want = 2;
                    else want = 0;
                    m_dir = want;
                    if (want != 0) begin
                        m_mode = 2; m_mv = 1; m_cnt = MT;
                    end
                end
            end
            2: begin
                if (m_cnt == 1) begin
                    m_floor = m_floor + ((m_dir == 1) ? 1 : -1);
                    m_arr = 1; m_mv = 0; m_mode = 1;
                end else m_cnt--;
            end
            default: begin
                if (here && prev_srv == 0) begin
                    m_cnt = DT; m_srv = 1 << m_floor;
                end else if (!bus.door_hold) begin
                    if (m_cnt == 1) begin
                        m_od = 0; m_mode = 1;
                    end else m_cnt--;
                end
            end
        endcase
    endtask

    // One clock: advance the model on the pre-edge inputs, then emulate the request register clear.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        req = req & ~bus.serviced;
        bus.eff_req = req;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.switch = 1'b1; bus.door_hold = 1'b0; set_req(4'b0000);
        cyc(); cyc();
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", bus.state); end
        checks++; if (bus.position !== 4'b0001) begin errors++; $display("FAIL reset_position: got %b want 0001", bus.position); end
        checks++;
        if ({bus.dir, bus.opendoor, bus.mv2nxt, bus.serviced, bus.arrive} !== 9'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 000000000", {bus.dir, bus.opendoor, bus.mv2nxt, bus.serviced, bus.arrive});
        end
        rst = 1'b0;
        cyc();
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL powerup_idle: got %b want 01", bus.state); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({bus.state, bus.position, bus.dir} !== 8'b01_0001_00) begin
                errors++; $display("FAIL idle_hold: got %b want 01000100", {bus.state, bus.position, bus.dir});
            end
        end
    endtask

    task automatic test_stop_home();
        int od_cnt, srv_cnt;
        logic mv_seen;
        set_req(4'b0001);
        cyc();
        checks++;
        if ({bus.opendoor, bus.serviced, bus.state} !== 7'b1_0001_11) begin
            errors++; $display("FAIL home_door_latency: got %b want 1000111", {bus.opendoor, bus.serviced, bus.state});
        end
        od_cnt = int'(bus.opendoor); srv_cnt = (bus.serviced != 0) ? 1 : 0; mv_seen = bus.mv2nxt;
        for (int i = 0; i < 6; i++) begin
            cyc();
            od_cnt += int'(bus.opendoor);
            if (bus.serviced != 0) srv_cnt++;
            mv_seen |= bus.mv2nxt;
        end
        checks++; if (od_cnt != 3) begin errors++; $display("FAIL home_door_len: got %0d want 3", od_cnt); end
        checks++; if (srv_cnt != 1) begin errors++; $display("FAIL home_serviced_len: got %0d want 1", srv_cnt); end
        checks++; if (mv_seen !== 1'b0) begin errors++; $display("FAIL home_no_motor: got %b want 0", mv_seen); end
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL home_back_idle: got %b want 01", bus.state); end
    endtask

    task automatic test_sweep_up();
        int mv_cnt = 0, arr_cnt = 0, od_cnt = 0;
        logic [11:0] pos_seq = '0;
        set_req(4'b1000);
        for (int i = 0; i < 25; i++) begin
            cyc();
            mv_cnt += int'(bus.mv2nxt);
            od_cnt += int'(bus.opendoor);
            if (bus.arrive) begin
                arr_cnt++;
                pos_seq = {pos_seq[7:0], bus.position};
            end
        end
        checks++; if (mv_cnt != 12) begin errors++; $display("FAIL sweep_motor_cycles: got %0d want 12", mv_cnt); end
        checks++; if (arr_cnt != 3) begin errors++; $display("FAIL sweep_arrivals: got %0d want 3", arr_cnt); end
        checks++; if (pos_seq !== 12'b0010_0100_1000) begin errors++; $display("FAIL sweep_positions: got %b want 001001001000", pos_seq); end
        checks++; if (od_cnt != 3) begin errors++; $display("FAIL sweep_door: got %0d want 3", od_cnt); end
        checks++;
        if ({bus.position, bus.state, bus.dir} !== 8'b1000_01_00) begin
            errors++; $display("FAIL sweep_final: got %b want 10000100", {bus.position, bus.state, bus.dir});
        end
    endtask

    task automatic test_scan_order();
        bit ok;
        logic [7:0]  srv_seq = '0;
        logic [29:0] arr_seq = '0;
        int n_srv = 0, n_arr = 0;
        set_req(4'b0001);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc();
            if (bus.state == 2'b01 && bus.position == 4'b0001 && req == 4'b0000) ok = 1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL scan_go_home: got timeout want idle at 0001"); end
        set_req(4'b1000);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc();
            if (bus.arrive && bus.position == 4'b0010) ok = 1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL scan_reach_f1: got timeout want arrive at 0010"); end
        set_req(req | 4'b0001);
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (bus.serviced != 0) begin n_srv++; srv_seq = {srv_seq[3:0], bus.serviced}; end
            if (bus.arrive) begin n_arr++; arr_seq = {arr_seq[23:0], bus.position, bus.dir}; end
        end
        checks++; if (n_srv != 2 || srv_seq !== 8'b1000_0001) begin errors++; $display("FAIL scan_service_order: got n=%0d %b want n=2 10000001", n_srv, srv_seq); end
        checks++;
        if (n_arr != 5 || arr_seq !== {4'b0100, 2'b01, 4'b1000, 2'b01, 4'b0100, 2'b10, 4'b0010, 2'b10, 4'b0001, 2'b10}) begin
            errors++; $display("FAIL scan_arrivals: got n=%0d %b", n_arr, arr_seq);
        end
        checks++;
        if ({bus.state, bus.position, bus.dir} !== 8'b01_0001_00) begin
            errors++; $display("FAIL scan_final: got %b want 01000100", {bus.state, bus.position, bus.dir});
        end
    endtask

    task automatic test_door_hold();
        int od_cnt;
        set_req(4'b0001);
        cyc(); od_cnt = int'(bus.opendoor);
        cyc(); od_cnt += int'(bus.opendoor);
        bus.door_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin cyc(); od_cnt += int'(bus.opendoor); end
        bus.door_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin cyc(); od_cnt += int'(bus.opendoor); end
        checks++; if (od_cnt != 8) begin errors++; $display("FAIL hold_door_len: got %0d want 8", od_cnt); end
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL hold_back_idle: got %b want 01", bus.state); end
        set_req(4'b0001);
        cyc(); cyc(); cyc();
        set_req(4'b0001);
        cyc();
        checks++;
        if ({bus.serviced, bus.opendoor} !== 5'b0001_1) begin
            errors++; $display("FAIL reload_strobe: got %b want 00011", {bus.serviced, bus.opendoor});
        end
        od_cnt = int'(bus.opendoor);
        for (int i = 0; i < 6; i++) begin cyc(); od_cnt += int'(bus.opendoor); end
        checks++; if (od_cnt != 3) begin errors++; $display("FAIL reload_door_len: got %0d want 3", od_cnt); end
    endtask

    task automatic test_abort();
        bit ok = 0;
        set_req(4'b1000);
        for (int i = 0; i < 30 && !ok; i++) begin
            cyc();
            if (bus.state == 2'b10 && bus.position == 4'b0100) ok = 1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL abort_reach_f2: got timeout want move at 0100"); end
        bus.switch = 1'b0;
        cyc();
        checks++;
        if ({bus.state, bus.position, bus.mv2nxt, bus.opendoor, bus.dir} !== 10'b00_0001_0_0_00) begin
            errors++; $display("FAIL abort_off: got %b want 0000010000", {bus.state, bus.position, bus.mv2nxt, bus.opendoor, bus.dir});
        end
        set_req(4'b0000);
        bus.switch = 1'b1;
        cyc();
        checks++;
        if ({bus.state, bus.position} !== 6'b01_0001) begin
            errors++; $display("FAIL abort_resume: got %b want 010001", {bus.state, bus.position});
        end
    endtask

    task automatic test_random();
        logic [14:0] got, exp;
        logic [3:0]  nb;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                nb = 4'b0001 << $urandom_range(0, 3);
                set_req(req | nb);
            end
            bus.door_hold = ($urandom_range(0, 3) == 0);
            bus.switch    = ($urandom_range(0, 299) != 0);
            cyc();
            exp = {2'(m_mode), 4'(1 << m_floor), 2'(m_dir), 1'(m_od), 1'(m_mv), 4'(m_srv), 1'(m_arr)};
            got = {bus.state, bus.position, bus.dir, bus.opendoor, bus.mv2nxt, bus.serviced, bus.arrive};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_cycle %0d: got %b want %b", i, got, exp);
            end
        end
        bus.door_hold = 1'b0;
        bus.switch    = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.switch = 1'b1;
        bus.door_hold = 1'b0;
        set_req(4'b0000);
        test_reset();
        test_stop_home();
        test_sweep_up();
        test_scan_order();
        test_door_hold();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
